wb_fir_bridge: RTL and testbench

Wishbone-slave to AXI bridge between the Caravel user-area Wishbone bus and the FIR wrapper in `user_proj_example`. Decodes a 256-byte FIR window and turns each Wishbone access into one AXI-Lite write, one AXI-Lite read, one AXI-Stream input beat, or one AXI-Stream output beat. Holds the Wishbone ack until the AXI handshake completes. Generates `ss_tlast` from a shadowed data-length register.

---
 rtl/wb_fir_bridge.sv | 197 +++++++++++++++++++
 tb/tb_wb_fir_bridge.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_fir_bridge.sv
// Wishbone slave that maps a 256-byte window onto the FIR's AXI-Lite config port
// and its AXI-Stream in/out ports, one AXI transfer per Wishbone access.
module wb_fir_bridge #(
  parameter logic [31:0] BASE        = 32'h3000_0000,
  parameter int          pADDR_WIDTH = 32,
  parameter int          pDATA_WIDTH = 32
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   ss_tvalid,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tlast,
  input  logic                   ss_tready,
  output logic                   sm_tready,
  input  logic                   sm_tvalid,
  input  logic [pDATA_WIDTH-1:0] sm_tdata,
  input  logic                   sm_tlast
);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_AR, S_R, S_SS, S_SM, S_ACK} state_t;

  state_t                 state, state_d;
  logic                   ack_d, awvalid_d, wvalid_d, arvalid_d, rready_d;
  logic                   ss_tvalid_d, ss_tlast_d, sm_tready_d;
  logic [31:0]            dat_d, len_r, len_d, x_cnt, x_cnt_d;
  logic [pADDR_WIDTH-1:0] awaddr_d, araddr_d;
  logic [pDATA_WIDTH-1:0] wdata_d, ss_tdata_d;

  // Byte selects and the FIR's own tlast carry no meaning for this bridge.
  logic in_unused;
  assign in_unused = ^{wbs_sel_i, sm_tlast};

  logic       req;
  logic [7:0] off;
  assign req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE[31:8]);
  assign off = wbs_adr_i[7:0];

  always_comb begin
    // NOTE: every target gets a default up front so no path leaves one unassigned
    // and infers a latch; registers hold, while ack and read data pulse to zero.
    state_d     = state;
    ack_d       = 1'b0;
    dat_d       = 32'd0;
    awvalid_d   = awvalid;
    wvalid_d    = wvalid;
    arvalid_d   = arvalid;
    rready_d    = rready;
    ss_tvalid_d = ss_tvalid;
    ss_tlast_d  = ss_tlast;
    sm_tready_d = sm_tready;
    awaddr_d    = awaddr;
    araddr_d    = araddr;
    wdata_d     = wdata;
    ss_tdata_d  = ss_tdata;
    len_d       = len_r;
    x_cnt_d     = x_cnt;

    case (state)
      S_IDLE: begin
        if (req && !wbs_ack_o) begin
          if (off < 8'h80) begin
            if (wbs_we_i) begin
              state_d   = S_AW;
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
              awaddr_d  = pADDR_WIDTH'(off);
              wdata_d   = pDATA_WIDTH'(wbs_dat_i);
            end else begin
              state_d   = S_AR;
              arvalid_d = 1'b1;
              araddr_d  = pADDR_WIDTH'(off);
            end
          end else if (off == 8'h80 && wbs_we_i) begin
            state_d     = S_SS;
            ss_tvalid_d = 1'b1;
            ss_tdata_d  = pDATA_WIDTH'(wbs_dat_i);
            ss_tlast_d  = (len_r != 32'd0) && (x_cnt == len_r - 32'd1);
          end else if (off == 8'h84 && !wbs_we_i) begin
            state_d     = S_SM;
            sm_tready_d = 1'b1;
          end else begin
            // Status read answers immediately; anything else acks with zero.
            state_d = S_ACK;
            ack_d   = 1'b1;
            if (off == 8'h88 && !wbs_we_i) dat_d = {30'd0, sm_tvalid, ss_tready};
          end
        end
      end
      S_AW: begin
        awvalid_d = awvalid & ~awready;
        wvalid_d  = wvalid & ~wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d = S_ACK;
          ack_d   = 1'b1;
          if (awaddr == pADDR_WIDTH'(8'h10)) begin
            len_d   = 32'(wdata);
            x_cnt_d = 32'd0;
          end
        end
      end
      S_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R;
        end
      end
      S_R: begin
        if (rvalid) begin
          rready_d = 1'b0;
          dat_d    = 32'(rdata);
          ack_d    = 1'b1;
          state_d  = S_ACK;
        end
      end
      S_SS: begin
        if (ss_tready) begin
          ss_tvalid_d = 1'b0;
          ss_tlast_d  = 1'b0;
          x_cnt_d     = ss_tlast ? 32'd0 : x_cnt + 32'd1;
          ack_d       = 1'b1;
          state_d     = S_ACK;
        end
      end
      S_SM: begin
        if (sm_tvalid) begin
          sm_tready_d = 1'b0;
          dat_d       = 32'(sm_tdata);
          ack_d       = 1'b1;
          state_d     = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (wb_rst_i) begin
      state     <= S_IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      ss_tvalid <= 1'b0;
      ss_tlast  <= 1'b0;
      sm_tready <= 1'b0;
      awaddr    <= '0;
      araddr    <= '0;
      wdata     <= '0;
      ss_tdata  <= '0;
      len_r     <= 32'd0;
      x_cnt     <= 32'd0;
    end else begin
      state     <= state_d;
      wbs_ack_o <= ack_d;
      wbs_dat_o <= dat_d;
      awvalid   <= awvalid_d;
      wvalid    <= wvalid_d;
      arvalid   <= arvalid_d;
      rready    <= rready_d;
      ss_tvalid <= ss_tvalid_d;
      ss_tlast  <= ss_tlast_d;
      sm_tready <= sm_tready_d;
      awaddr    <= awaddr_d;
      araddr    <= araddr_d;
      wdata     <= wdata_d;
      ss_tdata  <= ss_tdata_d;
      len_r     <= len_d;
      x_cnt     <= x_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_fir_bridge.sv
// Bench for wb_fir_bridge: directed and randomized Wishbone accesses against
// a transaction-level model of latency, read data, AXI activity and tlast.
module tb_wb_fir_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rready, rvalid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic        ss_tvalid, ss_tlast, ss_tready, sm_tready, sm_tvalid, sm_tlast;
  logic [31:0] ss_tdata, sm_tdata;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_fir_bridge #(.BASE(BASE), .pADDR_WIDTH(32), .pDATA_WIDTH(32)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rready(rready), .rvalid(rvalid), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tready(sm_tready), .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state: the FIR's config space and the stream length bookkeeping.
  logic [31:0] cfg_mem [0:127];
  logic [31:0] m_len, m_cnt;

  typedef enum {K_NONE, K_CW, K_CR, K_SS, K_SM, K_ST, K_MISS} kind_e;

  function automatic kind_e classify(input logic [31:0] addr, input logic wr);
    logic [7:0] off;
    off = addr[7:0];
    if (addr[31:8] != BASE[31:8]) return K_NONE;
    if (off < 8'h80)              return wr ? K_CW : K_CR;
    if (off == 8'h80 && wr)       return K_SS;
    if (off == 8'h84 && !wr)      return K_SM;
    if (off == 8'h88 && !wr)      return K_ST;
    return K_MISS;
  endfunction

  task automatic idle_inputs();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
    wbs_adr_i = 32'd0; wbs_dat_i = 32'd0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = $urandom;
    ss_tready = 1'b0; sm_tvalid = 1'b0; sm_tdata = $urandom; sm_tlast = 1'b0;
  endtask

  // One Wishbone access; d0/d1 are the stall counts of the AXI slave/stream peers.
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                         input int d0, input int d1);
    kind_e       k;
    logic [7:0]  off;
    int          lim, exp_lat, aw_n, w_n, ar_n, r_n, ss_n, sm_n, acks, ack_c, dat_bad;
    logic [31:0] exp_dat, dat_ack, got_awaddr, got_wdata, got_araddr, got_ss, sm_val;
    logic        exp_last, got_last, st_rdy, st_vld;
    k = classify(addr, wr);
    off = addr[7:0];
    lim = (k == K_NONE) ? 6 : 40;
    aw_n = 0; w_n = 0; ar_n = 0; r_n = 0; ss_n = 0; sm_n = 0;
    acks = 0; ack_c = -1; dat_bad = 0;
    exp_dat = 0; dat_ack = 0; got_awaddr = 0; got_wdata = 0; got_araddr = 0; got_ss = 0;
    exp_last = 1'b0; got_last = 1'b0;
    sm_val = $urandom;
    st_rdy = 1'($urandom_range(0, 1));
    st_vld = 1'($urandom_range(0, 1));
    case (k)
      K_CW:    exp_lat = ((d0 > d1) ? d0 : d1) + 2;
      K_CR:    begin exp_lat = d0 + d1 + 3; exp_dat = cfg_mem[off[6:0]]; end
      K_SS:    begin exp_lat = d0 + 2; exp_last = (m_len != 0) && (m_cnt == m_len - 1); end
      K_SM:    begin exp_lat = d0 + 2; exp_dat = sm_val; end
      K_ST:    begin exp_lat = 1; exp_dat = {30'd0, st_vld, st_rdy}; end
      K_MISS:  exp_lat = 1;
      default: exp_lat = -1;
    endcase

    wbs_adr_i = addr; wbs_we_i = wr; wbs_dat_i = data; wbs_sel_i = 4'($urandom);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    ss_tready = (k == K_ST) ? st_rdy : 1'b0;
    sm_tvalid = (k == K_ST) ? st_vld : 1'b0;

    for (int c = 1; c <= lim; c++) begin
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      if (wbs_ack_o) begin
        acks++;
        if (ack_c < 0) begin ack_c = c; dat_ack = wbs_dat_o; end
      end else if (wbs_dat_o != 0) dat_bad++;
      if (awvalid)   begin aw_n++; got_awaddr = awaddr; end
      if (wvalid)    begin w_n++;  got_wdata  = wdata; end
      if (arvalid)   begin ar_n++; got_araddr = araddr; end
      if (rready)    r_n++;
      if (ss_tvalid) begin ss_n++; got_ss = ss_tdata; got_last = ss_tlast; end
      if (sm_tready) sm_n++;
      awready   = awvalid && (aw_n > d0);
      wready    = wvalid && (w_n > d1);
      arready   = arvalid && (ar_n > d0);
      rvalid    = rready && (r_n > d1);
      rdata     = rvalid ? cfg_mem[got_araddr[6:0]] : $urandom;
      ss_tready = ss_tvalid && (ss_n > d0);
      sm_tvalid = sm_tready && (sm_n > d0);
      sm_tdata  = sm_tvalid ? sm_val : $urandom;
      if (ack_c == c) begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; end
      if (ack_c >= 0 && c == ack_c + 1) break;
    end
    idle_inputs();

    if (k == K_NONE) begin
      check("oow_ack", acks, 0);
      check("oow_axi", aw_n + w_n + ar_n + r_n + ss_n + sm_n, 0);
    end else begin
      check("ack_latency", ack_c, exp_lat);
      check("ack_count", acks, 1);
      check("ack_data", dat_ack, exp_dat);
      check("dat_zero_outside_ack", dat_bad, 0);
    end
    case (k)
      K_CW: begin
        check("awvalid_cycles", aw_n, d0 + 1);
        check("wvalid_cycles", w_n, d1 + 1);
        check("awaddr", got_awaddr, {24'd0, off});
        check("wdata", got_wdata, data);
        cfg_mem[off[6:0]] = data;
        if (off == 8'h10) begin m_len = data; m_cnt = 0; end
      end
      K_CR: begin
        check("arvalid_cycles", ar_n, d0 + 1);
        check("rready_cycles", r_n, d1 + 1);
        check("araddr", got_araddr, {24'd0, off});
      end
      K_SS: begin
        check("ss_tvalid_cycles", ss_n, d0 + 1);
        check("ss_tdata", got_ss, data);
        check("ss_tlast", got_last, exp_last);
        m_cnt = exp_last ? 0 : m_cnt + 1;
      end
      K_SM:         check("sm_tready_cycles", sm_n, d0 + 1);
      K_ST, K_MISS: check("no_axi_activity", aw_n + w_n + ar_n + r_n + ss_n + sm_n, 0);
      default: ;
    endcase
  endtask

  initial begin
    logic [31:0] addr, data;
    logic        wr;
    int          d0, d1;
    for (int i = 0; i < 128; i++) cfg_mem[i] = $urandom;
    cfg_mem[0] = 32'h4;
    m_len = 0;
    m_cnt = 0;
    idle_inputs();
    wb_rst_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("rst_ctrl", 32'({awvalid, wvalid, arvalid, rready, ss_tvalid, sm_tready, ss_tlast, wbs_ack_o}), 0);
    check("rst_dat_o", wbs_dat_o, 0);
    check("rst_addr", awaddr | araddr, 0);
    check("rst_data", wdata | ss_tdata, 0);
    wb_rst_i = 1'b0;

    run_txn(BASE | 32'h40, 1'b1, 32'd5, 3, 0);
    run_txn(BASE | 32'h00, 1'b0, 32'd0, 0, 2);
    run_txn(BASE | 32'h10, 1'b1, 32'd3, 0, 1);
    for (int b = 1; b <= 4; b++) run_txn(BASE | 32'h80, 1'b1, 32'(b), b % 2, 0);
    check("x_cnt_wrapped", m_cnt, 1);
    run_txn(BASE | 32'h84, 1'b0, 32'd0, 10, 0);
    run_txn(32'h3800_0000, 1'b0, 32'd0, 0, 0);
    run_txn(BASE | 32'h88, 1'b0, 32'd0, 0, 0);
    run_txn(BASE | 32'h80, 1'b0, 32'd0, 0, 0);
    run_txn(BASE | 32'h84, 1'b1, 32'hDEAD_BEEF, 0, 0);
    run_txn(BASE | 32'h88, 1'b1, 32'h1234_5678, 0, 0);

    // A length of 1 makes every beat tlast, so a length that survived reset shows up.
    run_txn(BASE | 32'h10, 1'b1, 32'd1, 0, 0);
    wbs_adr_i = BASE | 32'h04; wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    repeat (3) begin @(posedge wb_clk_i); @(negedge wb_clk_i); end
    check("arvalid_before_reset", 32'(arvalid), 1);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("arvalid_after_reset", 32'(arvalid), 0);
    check("ack_after_reset", 32'(wbs_ack_o), 0);
    wb_rst_i = 1'b0;
    idle_inputs();
    m_len = 0;
    m_cnt = 0;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("no_ack_post_reset", 32'(wbs_ack_o), 0);
    run_txn(BASE | 32'h80, 1'b1, 32'h0000_A5A5, 0, 0);

    for (int i = 0; i < 80; i++) begin
      d0 = $urandom_range(0, 3);
      d1 = $urandom_range(0, 3);
      data = $urandom;
      wr = 1'b0;
      case ($urandom_range(0, 7))
        0: begin addr = BASE | $urandom_range(0, 127); wr = 1'b1; end
        1: addr = BASE | $urandom_range(0, 127);
        2: begin addr = BASE | 32'h10; wr = 1'b1; data = $urandom_range(0, 3); end
        3, 4: begin addr = BASE | 32'h80; wr = 1'b1; end
        5: begin addr = BASE | 32'h84; d0 = $urandom_range(0, 6); end
        6: addr = BASE | 32'h88;
        default: begin
          wr = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 1) == 1) addr = 32'h4000_0000 | $urandom_range(0, 255);
          else                           addr = BASE | (32'h8C + $urandom_range(0, 32'h73));
        end
      endcase
      run_txn(addr, wr, data, d0, d1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
